// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO of arbitrary depth with fill level, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags. Occupancy is tracked by an explicit counter
// so that non-power-of-2 depths need no pointer-difference arithmetic.
module sync_fifo_prog #(
    parameter int SIZE     = 4,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = SIZE - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rdata_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(SIZE+1)-1:0]  level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int LW = $clog2(SIZE + 1);
    localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;

    // Elaboration-time parameter sanity checks
    if (SIZE < 2) begin : g_bad_size
        $error("sync_fifo_prog: SIZE must be >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_prog: WIDTH must be >= 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > SIZE) begin : g_bad_af
        $error("sync_fifo_prog: AF_LEVEL must be in 1..SIZE");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > SIZE - 1) begin : g_bad_ae
        $error("sync_fifo_prog: AE_LEVEL must be in 0..SIZE-1");
    end

    logic [WIDTH-1:0] mem [SIZE];

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             push_ok;
    logic             pop_ok;
    logic             mem_we;

    // Status decodes of the occupancy counter
    always_comb begin
        full         = (level_q == LW'(SIZE));
        empty        = (level_q == '0);
        almost_full  = (level_q >= LW'(AF_LEVEL));
        almost_empty = (level_q <= LW'(AE_LEVEL));
    end

    // Accept logic and next-state computation; flush overrides push/pop
    always_comb begin
        pop_ok        = pop && !empty;
        push_ok       = push && (!full || pop_ok);
        mem_we        = 1'b0;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        level_d       = level_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;

        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                mem_we = 1'b1;
                wptr_d = (wptr_q == PW'(SIZE - 1)) ? '0 : wptr_q + PW'(1);
            end
            if (pop_ok) begin
                rdata_d       = mem[rptr_q];
                rdata_valid_d = 1'b1;
                rptr_d        = (rptr_q == PW'(SIZE - 1)) ? '0 : rptr_q + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                level_d = level_q + LW'(1);
            end else if (pop_ok && !push_ok) begin
                level_d = level_q - LW'(1);
            end
            if (push && !push_ok) begin
                overflow_d = 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control and status registers, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            level_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            level_q       <= level_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // Storage array; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q] <= wdata;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule
